dice_ctrl: RTL
==============

Name: dice_ctrl

Overview:
- Controller at the other end of the dice counter's s/state interface.
- Debounces a raw push button and drives the counter's advance enable `s`: continuously while the button is held, then through a decelerating pulse train after release.
- Once the counter settles, captures the final face and presents it on a valid/ack handshake, with an optional 7-segment pip pattern.
- Sits between the board button/LEDs and the dice counter instance.

Parameters:
- DEB_CYC, 4, number of consecutive stable synchronized samples before the debounced button changes.
- SLOW_STEPS, 3, number of deceleration pulses issued after button release (gaps 1, 2, 4, ... cycles).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  asynchronous, active-low reset.
- btn  input  1  raw, asynchronous push button; 1 = pressed.
- face  input  3  current face from the dice counter (legal 1..6).
- ack  input  1  consumer accepts result; sampled only while valid=1.
- s  output  1  advance enable to the dice counter.
- busy  output  1  high in every state except IDLE.
- valid  output  1  result/err/pips are valid.
- result  output  3  captured face.
- err  output  1  captured face was 0 or 7.
- pips  output  7  pip pattern of result; bit order TL, TR, ML, C, MR, BL, BR = bits 0..6.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, s=0, busy=0, valid=0, result=0, err=0, pips=0, synchronizer and debounce state cleared, debounced button=0.
- Button input path:
  - btn passes through a 2-flop synchronizer.
  - The debounced level toggles after DEB_CYC consecutive rising edges in which the synchronized value differs from it; any agreeing sample clears the count.
  - press = rising edge of the debounced level, a one-cycle event.
- s and busy are decoded directly from the state register (Moore outputs, no extra delay).
- The counter advances on the rising edge ending any cycle in which s=1; face reflects that advance in the following cycle.
- FSM states IDLE, ROLL, DECEL, SETTLE, HOLD:
  - IDLE: s=0. press -> ROLL.
  - ROLL: s=1 every cycle. Debounced level 0 -> DECEL with gap=1 and step=0.
  - DECEL: s=0 for gap cycles, then s=1 for exactly one cycle. On that pulse cycle: step+1 and gap doubles. After pulse number SLOW_STEPS -> SETTLE. Gap counter is SLOW_STEPS+1 bits wide; no overflow at the maximum parameter.
  - SETTLE: s=0 for one cycle. At the end of the cycle, capture result<=face, set err when face is 0 or 7, set valid<=1, load pips. -> HOLD.
  - HOLD: outputs stable. ack=1 -> valid<=0, -> IDLE.
- Total s-high cycles per roll = ROLL cycles + SLOW_STEPS.
- Boundary conditions:
  - press in any state other than IDLE is discarded, not queued.
  - ack while valid=0 is ignored.
  - ack and press in the same cycle in HOLD: ack is honoured; the press is lost.
  - Button re-pressed during DECEL does not return to ROLL.
  - Button bounce shorter than DEB_CYC never produces press.
  - Reset mid-roll: s drops immediately; result is lost.

Optional Feature:
- Macro: DICE_CTRL_PIPS_EN.
- Defined: pips is a registered decode of the captured face, updated in SETTLE.
  - 1=0001000, 2=1000001, 3=1001001, 4=1100011, 5=1101011, 6=1110111 (bit6..bit0).
  - 0 or 7 decodes to 0000000.
- Undefined: the pips port remains and is tied to 0; no decode logic.

Decomposition:
- Shared package dice_pkg:
  - FSM state encodings (IDLE=0, ROLL=1, DECEL=2, SETTLE=3, HOLD=4, 3 bits).
  - Face constants FACE_MIN=1, FACE_MAX=6.
  - The six pip pattern constants.
- Sub-module dice_debounce (parameter DEB_CYC; ports clk, res, din, level, rise): contains the synchronizer, stable counter, and rising-edge pulse.

Test Plan (DEB_CYC=4, SLOW_STEPS=3 unless noted):
- Raw btn rises and holds -> s=1 in the cycle after the 7th rising edge (DEB_CYC+3); busy rises with s.
- btn glitches high for 3 cycles only -> s, busy and valid stay 0 throughout.
- Release after ROLL -> s pattern is 0,1,0,0,1,0,0,0,0,1, then one SETTLE cycle, then valid=1.
  - Counter starts at 1; bench counts n s-high cycles and requires result = (n mod 6)+1 and err=0.
  - With DICE_CTRL_PIPS_EN and result=5 -> pips = 1101011; without the macro -> pips = 0000000.
- valid=1, ack held low 20 cycles while btn is pressed again -> result stable, no new roll.
  - Then ack=1 -> valid=0 and IDLE next cycle.
- Force face=7 at the SETTLE capture -> valid=1, err=1, result=7, pips=0000000.
- res pulsed low during DECEL -> s=0 immediately and all outputs at reset values.
  - After release, a fresh press rolls normally.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared definitions for the dice controller: FSM encoding, legal face range
// and the seven-segment pip patterns (bit order TL,TR,ML,C,MR,BL,BR = 0..6).
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROLL   = 3'd1,
        DECEL  = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [2:0] FACE_MIN = 3'd1;
    localparam logic [2:0] FACE_MAX = 3'd6;

    localparam logic [6:0] PIPS_1 = 7'b0001000;
    localparam logic [6:0] PIPS_2 = 7'b1000001;
    localparam logic [6:0] PIPS_3 = 7'b1001001;
    localparam logic [6:0] PIPS_4 = 7'b1100011;
    localparam logic [6:0] PIPS_5 = 7'b1101011;
    localparam logic [6:0] PIPS_6 = 7'b1110111;

    // Illegal faces (0, 7) show a blank display.
    function automatic logic [6:0] pips_of(input logic [2:0] f);
        case (f)
            3'd1:    return PIPS_1;
            3'd2:    return PIPS_2;
            3'd3:    return PIPS_3;
            3'd4:    return PIPS_4;
            3'd5:    return PIPS_5;
            3'd6:    return PIPS_6;
            default: return 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/dice_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample counter and a
// one-cycle pulse on each rising edge of the debounced level.
module dice_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          rise_reg;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            rise_reg <= 1'b0;
            // Any sample that agrees with the current level restarts the count.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEB_CYC - 1)) begin
                cnt_reg   <= '0;
                level_reg <= ~level_reg;
                rise_reg  <= ~level_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/dice_ctrl.sv
// Dice roll controller: drives the counter enable while the button is held,
// then a decelerating pulse train, and presents the settled face on valid/ack.
// Optional pip decode is enabled with DICE_CTRL_PIPS_EN.
module dice_ctrl
    import dice_pkg::*;
#(
    parameter int DEB_CYC    = 4,
    parameter int SLOW_STEPS = 3
) (
    input  logic       clk,
    input  logic       res,
    input  logic       btn,
    input  logic [2:0] face,
    input  logic       ack,
    output logic       s,
    output logic       busy,
    output logic       valid,
    output logic [2:0] result,
    output logic       err,
    output logic [6:0] pips
);

    localparam int GW = SLOW_STEPS + 1;
    localparam int SW = (SLOW_STEPS < 2) ? 1 : $clog2(SLOW_STEPS);

    logic level;
    logic press;

    dice_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
        .clk   (clk),
        .res   (res),
        .din   (btn),
        .level (level),
        .rise  (press)
    );

    state_t        state_reg, state_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [GW-1:0] wait_reg, wait_next;
    logic [SW-1:0] step_reg, step_next;
    logic          capture;
    logic          release_result;

    logic          valid_reg;
    logic [2:0]    result_reg;
    logic          err_reg;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
            wait_reg  <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            wait_reg  <= wait_next;
            step_reg  <= step_next;
        end
    end

    // In DECEL the enable pulses on the cycle the gap countdown reaches zero.
    assign s    = (state_reg == ROLL) || ((state_reg == DECEL) && (wait_reg == '0));
    assign busy = (state_reg != IDLE);

    always_comb begin
        state_next     = state_reg;
        gap_next       = gap_reg;
        wait_next      = wait_reg;
        step_next      = step_reg;
        capture        = 1'b0;
        release_result = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press) state_next = ROLL;
            end
            ROLL: begin
                if (!level) begin
                    state_next = DECEL;
                    gap_next   = GW'(1);
                    wait_next  = GW'(1);
                    step_next  = '0;
                end
            end
            DECEL: begin
                if (wait_reg != '0) begin
                    wait_next = wait_reg - 1'b1;
                end else begin
                    step_next = step_reg + 1'b1;
                    gap_next  = gap_reg << 1;
                    wait_next = gap_reg << 1;
                    if (step_reg == SW'(SLOW_STEPS - 1)) state_next = SETTLE;
                end
            end
            SETTLE: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (ack) begin
                    release_result = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            valid_reg  <= 1'b0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else if (capture) begin
            valid_reg  <= 1'b1;
            result_reg <= face;
            err_reg    <= (face < FACE_MIN) || (face > FACE_MAX);
        end else if (release_result) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid  = valid_reg;
    assign result = result_reg;
    assign err    = err_reg;

`ifdef DICE_CTRL_PIPS_EN
    logic [6:0] pips_reg;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pips_reg <= '0;
        end else if (capture) begin
            pips_reg <= pips_of(face);
        end
    end

    assign pips = pips_reg;
`else
    assign pips = '0;
`endif

endmodule
